dtfag_index_seq: RTL

- Upstream sequencer for the DTFAG address generator in the R16 65536-point FFT twiddle path.
- Walks the (stage t, butterfly i, radix-element j) index space of the selected FFT stages.
- Emits one index triple per accepted beat, under valid/ready, to the AGU inputs DTFAG_t / DTFAG_i / DTFAG_j.
- Start/busy/done handshake toward the FFT controller.

---
 rtl/dtfag_index_seq_if.sv | 30 +++
 rtl/dtfag_index_seq.sv | 122 ++++++++++++
 2 files changed

// File: rtl/dtfag_index_seq_if.sv
// Index-stream and control bundle between the FFT controller, dtfag_index_seq and the DTFAG AGU.
// The master modport is the sequencer side; the slave modport is the controller/AGU side.
interface dtfag_index_seq_if #(
  parameter int unsigned T_W       = 2,
  parameter int unsigned I_W       = 12,
  parameter int unsigned RADIX_LOG = 4
);
  logic                 start;
  logic [T_W-1:0]       cfg_stage_first;
  logic [T_W-1:0]       cfg_stage_last;
  logic                 busy;
  logic                 done;
  logic [T_W-1:0]       DTFAG_t;
  logic [I_W-1:0]       DTFAG_i;
  logic [RADIX_LOG-1:0] DTFAG_j;
  logic                 idx_valid;
  logic                 idx_ready;
  logic                 idx_last_j;
  logic                 idx_last;

  modport master (
    input  start, cfg_stage_first, cfg_stage_last, idx_ready,
    output busy, done, DTFAG_t, DTFAG_i, DTFAG_j, idx_valid, idx_last_j, idx_last
  );

  modport slave (
    output start, cfg_stage_first, cfg_stage_last, idx_ready,
    input  busy, done, DTFAG_t, DTFAG_i, DTFAG_j, idx_valid, idx_last_j, idx_last
  );
endinterface

// File: rtl/dtfag_index_seq.sv
// Walks (stage t, butterfly i, radix element j) for the DTFAG AGU under valid/ready.
// Define DTFAG_SKIP_J0_EN to skip j = 0 (the W^0 twiddle needs no ROM access).
module dtfag_index_seq #(
  parameter int unsigned N_LOG     = 16,
  parameter int unsigned RADIX_LOG = 4,
  parameter int unsigned T_W       = 2
) (
  input logic               clk,
  input logic               rst,
  dtfag_index_seq_if.master bus
);
  localparam int unsigned I_W = N_LOG - RADIX_LOG;
  localparam logic [I_W-1:0]       I_MAX = '1;
  localparam logic [RADIX_LOG-1:0] J_MAX = '1;
`ifdef DTFAG_SKIP_J0_EN
  localparam logic [RADIX_LOG-1:0] J_MIN = RADIX_LOG'(1);
`else
  localparam logic [RADIX_LOG-1:0] J_MIN = '0;
`endif

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e               state_q;
  logic [T_W-1:0]       cfg_first_q, cfg_last_q;
  logic [T_W-1:0]       t_q;
  logic [I_W-1:0]       i_q;
  logic [RADIX_LOG-1:0] j_q;
  logic                 valid_q, busy_q, done_q, last_j_q, flag_last_q;

  logic                 j_wrap, i_wrap;
  logic [T_W-1:0]       t_nxt;
  logic [I_W-1:0]       i_nxt;
  logic [RADIX_LOG-1:0] j_nxt;
  logic                 last_j_nxt, last_nxt;

  // Next triple and its flags, so both flags can be registered alongside the counters.
  always_comb begin
    j_wrap     = (j_q == J_MAX);
    i_wrap     = j_wrap && (i_q == I_MAX);
    j_nxt      = j_wrap ? J_MIN : j_q + 1'b1;
    i_nxt      = j_wrap ? i_q + 1'b1 : i_q;
    t_nxt      = i_wrap ? t_q + 1'b1 : t_q;
    last_j_nxt = (j_nxt == J_MAX);
    last_nxt   = last_j_nxt && (i_nxt == I_MAX) && (t_nxt == cfg_last_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cfg_first_q <= '0;
      cfg_last_q  <= '0;
      t_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      last_j_q    <= 1'b0;
      flag_last_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.start) begin
            cfg_first_q <= bus.cfg_stage_first;
            cfg_last_q  <= bus.cfg_stage_last;
            if (bus.cfg_stage_first <= bus.cfg_stage_last) begin
              state_q     <= StRun;
              t_q         <= bus.cfg_stage_first;
              i_q         <= '0;
              j_q         <= J_MIN;
              valid_q     <= 1'b1;
              busy_q      <= 1'b1;
              last_j_q    <= (J_MIN == J_MAX);
              flag_last_q <= (J_MIN == J_MAX) && (I_MAX == '0) &&
                             (bus.cfg_stage_first == bus.cfg_stage_last);
            end else begin
              state_q <= StFin;
            end
          end
        end
        StRun: begin
          if (valid_q && bus.idx_ready) begin
            if (flag_last_q) begin
              state_q     <= StFin;
              valid_q     <= 1'b0;
              busy_q      <= 1'b0;
              last_j_q    <= 1'b0;
              flag_last_q <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              t_q         <= t_nxt;
              i_q         <= i_nxt;
              j_q         <= j_nxt;
              last_j_q    <= last_j_nxt;
              flag_last_q <= last_nxt;
            end
          end
        end
        // An empty configuration enters FIN with done low and raises it one cycle later.
        StFin: begin
          if (done_q) begin
            done_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.DTFAG_t    = t_q;
  assign bus.DTFAG_i    = i_q;
  assign bus.DTFAG_j    = j_q;
  assign bus.idx_valid  = valid_q;
  assign bus.idx_last_j = last_j_q;
  assign bus.idx_last   = flag_last_q;
endmodule
